// File: rtl/mem_stage_mc_pkg.sv
// Shared definitions for the MEM stage: bus widths, field offsets, ld_size/sel encodings, FSM states.
package mem_stage_mc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } mem_state_e;

  localparam logic [1:0] LD_BYTE  = 2'b00;
  localparam logic [1:0] LD_HALF  = 2'b01;
  localparam logic [1:0] LD_WORD  = 2'b10;
  localparam logic [1:0] LD_DWORD = 2'b11;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_PC8  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // EXE->MEM low-order control fields; rf_waddr, alu_res, pc_plus_4 follow upward
  localparam int unsigned EM_LD_UNS_OFF   = 0;
  localparam int unsigned EM_LD_SIZE_OFF  = 1;
  localparam int unsigned EM_IS_LOAD_OFF  = 3;
  localparam int unsigned EM_RF_WE_OFF    = 4;
  localparam int unsigned EM_SEL_OFF      = 5;
  localparam int unsigned EM_RF_WADDR_OFF = 7;

  function automatic int unsigned exe_to_mem_bus_wd(int unsigned pc_w, int unsigned data_w,
                                                    int unsigned reg_aw);
    return pc_w + data_w + reg_aw + 7;
  endfunction

  function automatic int unsigned mem_to_wb_bus_wd(int unsigned pc_w, int unsigned data_w,
                                                   int unsigned reg_aw);
    return pc_w + data_w + reg_aw + 1;
  endfunction

  function automatic int unsigned mem_to_by_bus_wd(int unsigned data_w, int unsigned reg_aw);
    return reg_aw + data_w + 3;
  endfunction

endpackage

// File: rtl/mem_stage_mc_load_align.sv
// Combinational load lane select and sign/zero extension for byte/half/word/dword loads.
module mem_stage_mc_load_align
  import mem_stage_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]              data,
  input  logic [$clog2(DATA_W/8)-1:0]    offset,
  input  logic [1:0]                     size,
  input  logic                           is_unsigned,
  output logic [DATA_W-1:0]              result
);

  localparam int unsigned OFF_W = $clog2(DATA_W/8);

  logic [OFF_W-1:0]  lane;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;

  // Address bits below the access size are dropped so the lane is always size-aligned
  always_comb begin
    lane = offset;
    mask = '1;
    case (size)
      LD_BYTE: begin lane = offset;                 mask = DATA_W'(8'hFF);        end
      LD_HALF: begin lane = offset & ~OFF_W'(1);    mask = DATA_W'(16'hFFFF);     end
      LD_WORD: begin lane = offset & ~OFF_W'(3);    mask = DATA_W'(32'hFFFF_FFFF); end
      default: begin lane = '0;                     mask = '1;                    end
    endcase
    shifted = data >> {lane, 3'b000};
    // mask ^ (mask >> 1) isolates the top bit of the selected field
    sign    = ~is_unsigned & (|(shifted & (mask ^ (mask >> 1))));
    result  = (shifted & mask) | (sign ? ~mask : '0);
  end

endmodule

// File: rtl/mem_stage_mc.sv
// MEM pipeline stage with variable-latency load response, hold buffer and bypass bus.
// Optional MEM_LOAD_BYPASS_EN: forward load data on the bypass bus once the response is in.
module mem_stage_mc
  import mem_stage_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_W   = 32
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              EXE_to_MEM_valid,
  output logic                                              MEM_allow_in,
  input  logic [exe_to_mem_bus_wd(PC_W, DATA_W, REG_AW)-1:0] EXE_to_MEM_bus,
  input  logic                                              WB_allow_in,
  output logic                                              MEM_to_WB_valid,
  output logic [mem_to_wb_bus_wd(PC_W, DATA_W, REG_AW)-1:0]  MEM_to_WB_bus,
  output logic [mem_to_by_bus_wd(DATA_W, REG_AW)-1:0]        MEM_to_BY_bus,
  input  logic                                              data_ram_r_valid,
  input  logic [DATA_W-1:0]                                 data_ram_r_data
);

  localparam int unsigned EM_W    = exe_to_mem_bus_wd(PC_W, DATA_W, REG_AW);
  localparam int unsigned ALU_OFF = EM_RF_WADDR_OFF + REG_AW;
  localparam int unsigned PC_OFF  = ALU_OFF + DATA_W;
  localparam int unsigned OFF_W   = $clog2(DATA_W/8);

  logic [EM_W-1:0]   stage_q;
  logic              mem_valid;
  mem_state_e        state;
  logic [DATA_W-1:0] hold_q;

  logic [PC_W-1:0]   pc_plus_4;
  logic [DATA_W-1:0] alu_res;
  logic [REG_AW-1:0] rf_waddr;
  logic [1:0]        sel_rf_w_data;
  logic              rf_we;
  logic              is_load;
  logic [1:0]        ld_size;
  logic              ld_unsigned;

  assign pc_plus_4     = stage_q[PC_OFF +: PC_W];
  assign alu_res       = stage_q[ALU_OFF +: DATA_W];
  assign rf_waddr      = stage_q[EM_RF_WADDR_OFF +: REG_AW];
  assign sel_rf_w_data = stage_q[EM_SEL_OFF +: 2];
  assign rf_we         = stage_q[EM_RF_WE_OFF];
  assign is_load       = stage_q[EM_IS_LOAD_OFF];
  assign ld_size       = stage_q[EM_LD_SIZE_OFF +: 2];
  assign ld_unsigned   = stage_q[EM_LD_UNS_OFF];

  logic resp_have, ready_go, accept, fire, new_load;

  // A response arriving while waiting counts immediately (zero-cycle pass-through)
  assign resp_have       = (state == S_HOLD) | ((state == S_WAIT) & data_ram_r_valid);
  assign ready_go        = ~is_load | resp_have;
  assign MEM_allow_in    = ~mem_valid | (WB_allow_in & ready_go);
  assign MEM_to_WB_valid = mem_valid & ready_go;
  assign accept          = EXE_to_MEM_valid & MEM_allow_in;
  assign fire            = MEM_to_WB_valid & WB_allow_in;
  assign new_load        = accept & EXE_to_MEM_bus[EM_IS_LOAD_OFF];

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q   <= '0;
      mem_valid <= 1'b0;
      hold_q    <= '0;
      state     <= S_IDLE;
    end else begin
      if (MEM_allow_in) mem_valid <= EXE_to_MEM_valid;
      if (accept)       stage_q   <= EXE_to_MEM_bus;
      if ((state == S_WAIT) && data_ram_r_valid) hold_q <= data_ram_r_data;
      case (state)
        S_IDLE: if (new_load) state <= S_WAIT;
        S_WAIT: begin
          if (data_ram_r_valid) begin
            if (new_load)  state <= S_WAIT;
            else if (fire) state <= S_IDLE;
            else           state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (new_load)  state <= S_WAIT;
          else if (fire) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] ld_src;
  logic [DATA_W-1:0] ld_data;

  assign ld_src = (state == S_HOLD) ? hold_q : data_ram_r_data;

  mem_stage_mc_load_align #(.DATA_W(DATA_W)) u_load_align (
    .data        (ld_src),
    .offset      (alu_res[OFF_W-1:0]),
    .size        (ld_size),
    .is_unsigned (ld_unsigned),
    .result      (ld_data)
  );

  logic [PC_W-1:0]   pc_plus_8;
  logic [DATA_W-1:0] rf_wdata;

  assign pc_plus_8 = pc_plus_4 + PC_W'(4);

  always_comb begin
    rf_wdata = '0;
    case (sel_rf_w_data)
      SEL_ALU:  rf_wdata = alu_res;
      SEL_PC8:  rf_wdata = DATA_W'(pc_plus_8);
      SEL_LOAD: rf_wdata = ld_data;
      default:  rf_wdata = '0;
    endcase
  end

  logic ld_pending;
`ifdef MEM_LOAD_BYPASS_EN
  assign ld_pending = mem_valid & is_load & ~resp_have;

  stray_resp_chk: assert property (@(posedge clk) disable iff (!reset)
                                   data_ram_r_valid |-> (state == S_WAIT));
`else
  // Without load bypass, ID must stall until the load has left for WB
  assign ld_pending = mem_valid & is_load;
`endif

  assign MEM_to_WB_bus = {pc_plus_4, rf_wdata, rf_waddr, rf_we};
  assign MEM_to_BY_bus = {rf_waddr, rf_wdata, rf_we, mem_valid, ld_pending};

endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
- Next-generation MEM pipeline stage of the five-stage MIPS-style core.
- Sits between EXE and WB, with the same valid/allow_in pipeline handshake as the other stages.
- Adds a variable-latency data-memory response handshake, a load-response holding buffer, and byte/halfword load extraction with sign or zero extension.
- Drives the MEM-to-bypass bus with a load-pending flag, so ID can stall instead of forwarding stale data.

Parameters:
- DATA_W, 32, datapath and register width (must be 32 or 64).
- REG_AW, 5, register-file address width.
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset; all state is cleared on a rising edge of clk while low.
- EXE_to_MEM_valid  in  1  EXE holds a valid instruction.
- MEM_allow_in  out  1  MEM can accept from EXE this cycle.
- EXE_to_MEM_bus  in  EXE_TO_MEM_BUS_WD  fields {pc_plus_4, alu_res, rf_waddr, sel_rf_w_data[1:0], rf_we, is_load, ld_size[1:0], ld_unsigned}.
- WB_allow_in  in  1  WB can accept.
- MEM_to_WB_valid  out  1  MEM output valid.
- MEM_to_WB_bus  out  MEM_TO_WB_BUS_WD  fields {pc_plus_4, rf_wdata, rf_waddr, rf_we}.
- MEM_to_BY_bus  out  MEM_TO_BY_BUS_WD  fields {rf_waddr, rf_wdata, rf_we, MEM_valid, ld_pending}.
- data_ram_r_valid  in  1  load response strobe.
- data_ram_r_data  in  DATA_W  load response data.

Behaviour:
- Reset values:
  - MEM_valid=0 and FSM=IDLE.
  - Hold buffer and stage register cleared to 0.
  - Outputs at reset: MEM_to_WB_valid=0, MEM_allow_in=1, bypass bus all 0.
- Stage register:
  - Loads EXE_to_MEM_bus when EXE_to_MEM_valid & MEM_allow_in.
  - MEM_valid <= EXE_to_MEM_valid whenever MEM_allow_in.
- Handshake equations:
  - MEM_ready_go = ~is_load | resp_have.
  - MEM_allow_in = ~MEM_valid | (WB_allow_in & MEM_ready_go).
  - MEM_to_WB_valid = MEM_valid & MEM_ready_go.
- FSM states:
  - IDLE: no outstanding load.
  - WAIT: load in MEM, response not yet received.
  - HOLD: response captured, not yet passed to WB.
- FSM transitions:
  - IDLE->WAIT when a load is accepted into MEM.
  - WAIT->HOLD on data_ram_r_valid; data is captured into the hold buffer and resp_have=1.
  - HOLD->IDLE when MEM_to_WB_valid & WB_allow_in.
  - If a new load is accepted in that same cycle, HOLD->WAIT directly.
  - WAIT with data_ram_r_valid & WB_allow_in: pass the response combinationally in the same cycle (zero-cycle path); no HOLD visit.
- Stray responses: data_ram_r_valid in IDLE or HOLD is ignored (flagged by the assertion under the optional feature).
- Load extraction:
  - Byte lane selected by alu_res[$clog2(DATA_W/8)-1:0].
  - ld_size 00=byte, 01=half, 10=word, 11=dword (dword legal only when DATA_W=64).
  - Extension is sign or zero per ld_unsigned.
  - Misaligned accesses are not checked here; lower address bits beyond the size are ignored.
- rf_wdata select by sel_rf_w_data:
  - 00 = alu_res.
  - 01 = pc_plus_4+4, zero-extended to DATA_W.
  - 10 = extracted load data.
  - 11 = 0.
- Bypass bus:
  - ld_pending = MEM_valid & is_load & ~resp_have.
  - rf_wdata is only meaningful when ld_pending=0.
- Reset mid-operation: an outstanding load is abandoned and the FSM returns to IDLE. A response arriving after reset is ignored.
- Back-pressure: with WB_allow_in=0, all MEM outputs and the hold buffer stay stable.

Optional Feature:
- Macro: MEM_LOAD_BYPASS_EN.
- Defined:
  - When resp_have=1 (or on the same-cycle response), the bypass bus carries the extracted load data with ld_pending=0, so ID forwards it.
  - Simulation-only assertion fires on a stray data_ram_r_valid.
- Undefined:
  - ld_pending stays 1 for any load in MEM, regardless of response, so ID stalls until the load reaches WB.
  - No assertion.

Decomposition:
- Shared package/header (myCPU.h), holding:
  - EXE_TO_MEM_BUS_WD, MEM_TO_WB_BUS_WD, MEM_TO_BY_BUS_WD.
  - Field offset constants.
  - ld_size encodings.
  - sel_rf_w_data encodings.
  - FSM state encodings.
- Sub-module load_align: purely combinational lane select and extension, parametrised by DATA_W.

Test Plan:
1. ALU instruction, alu_res=0x0000_1234, sel=00, WB_allow_in=1:
   - MEM_to_WB_valid=1 the cycle after acceptance.
   - rf_wdata=0x1234.
   - ld_pending=0.
2. lb, alu_res[1:0]=2, response 0x0080_0000 three cycles later:
   - MEM_allow_in=0 and ld_pending=1 for cycles 1–3.
   - rf_wdata=0xFFFF_FF80 in the response cycle.
   - lbu of the same gives 0x80.
3. lh response arrives while WB_allow_in=0 for 2 cycles:
   - FSM enters HOLD and data is held stable.
   - Forwarded to WB on the first cycle WB_allow_in=1.
   - Next instruction is accepted in the same cycle.
4. Back-to-back loads, second accepted in the HOLD->WB cycle:
   - FSM goes HOLD->WAIT directly.
   - No response is lost or duplicated.
5. reset low during WAIT, then data_ram_r_valid after reset is released:
   - MEM_valid=0 and FSM=IDLE.
   - The late response produces no MEM_to_WB_valid.
6. jal, sel=01, pc_plus_4=0xBFC0_0004:
   - rf_wdata=0xBFC0_0008.
   - With MEM_LOAD_BYPASS_EN undefined, a load shows ld_pending=1 even after its response.
